// File: rtl/dvi_pll_rst_seq.sv
// Reset/lock sequencer for the DVI clocking PLL: pulses the PLL reset, waits for a stable lock,
// then releases the DVI datapath; re-runs the PLL reset on lock timeout or filtered loss of lock.
module dvi_pll_rst_seq #(
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOSS_FILT_CYC    = 4,
    parameter int CNT_W            = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       dvi_rst,
    output logic       ready,
    output logic [7:0] relock_cnt,
    output logic [7:0] timeout_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_PLLRST    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST    = CNT_W'(LOSS_FILT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    // Statistics counters stick at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'd255) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    logic             lock_meta_r;
    logic             lock_sync_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_nxt_s;
    logic [CNT_W-1:0] loss_r;
    logic [CNT_W-1:0] loss_nxt_s;
    logic             relock_inc_s;
    logic             timeout_inc_s;
    logic [7:0]       relock_cnt_r;
    logic [7:0]       timeout_cnt_r;
    logic             pll_rst_nxt_s;
    logic             dvi_rst_nxt_s;
    logic             ready_nxt_s;
    logic             pll_rst_r;
    logic             dvi_rst_r;
    logic             ready_r;

    // Two-flop synchronizer bringing the asynchronous PLL lock into refclk.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // State register with its timer, loss filter and statistics counters.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r       <= ST_PLLRST;
            timer_r       <= CNT_ZERO;
            loss_r        <= CNT_ZERO;
            relock_cnt_r  <= 8'd0;
            timeout_cnt_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            loss_r  <= loss_nxt_s;
            if (relock_inc_s) begin
                relock_cnt_r <= sat_inc8(relock_cnt_r);
            end else begin
                relock_cnt_r <= relock_cnt_r;
            end
            if (timeout_inc_s) begin
                timeout_cnt_r <= sat_inc8(timeout_cnt_r);
            end else begin
                timeout_cnt_r <= timeout_cnt_r;
            end
        end
    end

    // Next-state logic; lock checks win over the timer in WAIT_LOCK and STABLE.
    always_comb begin
        state_nxt_s   = state_r;
        loss_nxt_s    = CNT_ZERO;
        relock_inc_s  = 1'b0;
        timeout_inc_s = 1'b0;
        case (state_r)
            ST_PLLRST: begin
                if (timer_r == RST_LAST) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else begin
                    state_nxt_s = ST_PLLRST;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_sync_r) begin
                    state_nxt_s = ST_STABLE;
                end else if (timer_r == TIMEOUT_LAST) begin
                    state_nxt_s   = ST_PLLRST;
                    timeout_inc_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!lock_sync_r) begin
                    state_nxt_s = ST_PLLRST;
                end else if (timer_r == STABLE_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STABLE;
                end
            end
            ST_RUN: begin
                if (lock_sync_r) begin
                    state_nxt_s = ST_RUN;
                    loss_nxt_s  = CNT_ZERO;
                end else if (loss_r == LOSS_LAST) begin
                    state_nxt_s  = ST_PLLRST;
                    loss_nxt_s   = CNT_ZERO;
                    relock_inc_s = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                    loss_nxt_s  = loss_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_PLLRST;
            end
        endcase
        if (state_nxt_s != state_r) begin
            timer_nxt_s = CNT_ZERO;
        end else begin
            timer_nxt_s = timer_r + CNT_ONE;
        end
    end

    // Moore output decode of the upcoming state, so registered outputs align with state_r.
    always_comb begin
        pll_rst_nxt_s = 1'b1;
        dvi_rst_nxt_s = 1'b1;
        ready_nxt_s   = 1'b0;
        case (state_nxt_s)
            ST_PLLRST: begin
                pll_rst_nxt_s = 1'b1;
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                pll_rst_nxt_s = 1'b0;
            end
            ST_RUN: begin
                pll_rst_nxt_s = 1'b0;
                dvi_rst_nxt_s = 1'b0;
                ready_nxt_s   = 1'b1;
            end
            default: begin
                pll_rst_nxt_s = 1'b1;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst_r <= 1'b1;
            dvi_rst_r <= 1'b1;
            ready_r   <= 1'b0;
        end else begin
            pll_rst_r <= pll_rst_nxt_s;
            dvi_rst_r <= dvi_rst_nxt_s;
            ready_r   <= ready_nxt_s;
        end
    end

    assign pll_rst     = pll_rst_r;
    assign dvi_rst     = dvi_rst_r;
    assign ready       = ready_r;
    assign relock_cnt  = relock_cnt_r;
    assign timeout_cnt = timeout_cnt_r;
    assign state       = state_r;

    dvi_pll_rst_seq_chk u_chk (
        .clk     (refclk),
        .rst     (rst),
        .pll_rst (pll_rst_r),
        .dvi_rst (dvi_rst_r),
        .ready   (ready_r),
        .state   (state_r)
    );

endmodule

// Output consistency properties for the sequencer.
module dvi_pll_rst_seq_chk (
    input logic       clk,
    input logic       rst,
    input logic       pll_rst,
    input logic       dvi_rst,
    input logic       ready,
    input logic [1:0] state
);

    a_ready_inv: assert property (@(posedge clk) disable iff (rst) ready == !dvi_rst);
    a_dvi_only_run: assert property (@(posedge clk) disable iff (rst) (!dvi_rst) == (state == 2'd3));
    a_pll_rst_decode: assert property (@(posedge clk) disable iff (rst) pll_rst == (state == 2'd0));

endmodule

// File: tb/tb_dvi_pll_rst_seq.sv
// Directed bench for dvi_pll_rst_seq with short timing parameters and hand-derived cycle counts.
module tb_dvi_pll_rst_seq;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       dvi_rst;
    logic       ready;
    logic [7:0] relock_cnt;
    logic [7:0] timeout_cnt;
    logic [1:0] state;

    int n_checks;
    int n_fail;

    dvi_pll_rst_seq #(
        .PLL_RST_CYC      (4),
        .LOCK_TIMEOUT_CYC (20),
        .LOCK_STABLE_CYC  (8),
        .LOSS_FILT_CYC    (3),
        .CNT_W            (16)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .dvi_rst     (dvi_rst),
        .ready       (ready),
        .relock_cnt  (relock_cnt),
        .timeout_cnt (timeout_cnt),
        .state       (state)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (5) tick();
        n_checks++;
        if ({state, pll_rst, dvi_rst, ready} !== {2'd0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got st=%0d pr=%b dr=%b rdy=%b expected st=0 pr=1 dr=1 rdy=0",
                     state, pll_rst, dvi_rst, ready);
        end
        n_checks++;
        if ({relock_cnt, timeout_cnt} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_stats: got relock=%0d timeout=%0d expected 0 0", relock_cnt, timeout_cnt);
        end
        rst = 1'b0;
    endtask

    // Entered right after rst is released with pll_locked low; ends on the edge RUN is entered.
    task automatic do_bringup(input string tag);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (pll_rst !== 1'b1 || state !== 2'd0) begin
                n_fail++;
                $display("FAIL %s_pllrst_hold: edge %0d got pr=%b st=%0d expected pr=1 st=0", tag, i, pll_rst, state);
            end
        end
        tick();
        n_checks++;
        if (pll_rst !== 1'b0 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL %s_pllrst_fall: got pr=%b st=%0d expected pr=0 st=1", tag, pll_rst, state);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (state !== 2'd1 || dvi_rst !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_wait_lock: cycle %0d got st=%0d dr=%b expected st=1 dr=1", tag, i, state, dvi_rst);
            end
        end
        pll_locked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_checks++;
            if (dvi_rst !== 1'b1 || ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_early_release: edge %0d got dr=%b rdy=%b expected dr=1 rdy=0", tag, i, dvi_rst, ready);
            end
            if (i == 3) begin
                n_checks++;
                if (state !== 2'd2) begin
                    n_fail++;
                    $display("FAIL %s_enter_stable: got st=%0d expected 2", tag, state);
                end
            end
        end
        tick();
        n_checks++;
        if ({state, pll_rst, dvi_rst, ready} !== {2'd3, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_release: got st=%0d pr=%b dr=%b rdy=%b expected st=3 pr=0 dr=0 rdy=1",
                     tag, state, pll_rst, dvi_rst, ready);
        end
        n_checks++;
        if ({relock_cnt, timeout_cnt} !== 16'h0000) begin
            n_fail++;
            $display("FAIL %s_stats: got relock=%0d timeout=%0d expected 0 0", tag, relock_cnt, timeout_cnt);
        end
    endtask

    task automatic test_bringup();
        do_bringup("bringup");
    endtask

    task automatic test_run_glitch();
        pll_locked = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++;
            if (state !== 2'd3 || relock_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL glitch_filtered: cycle %0d got st=%0d relock=%0d expected st=3 relock=0", i, state, relock_cnt);
            end
        end
        pll_locked = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 3) pll_locked = 1'b1;
            n_checks++;
            if (state !== 2'd3) begin
                n_fail++;
                $display("FAIL loss_early: edge %0d got st=%0d expected 3", i, state);
            end
        end
        tick();
        n_checks++;
        if ({state, pll_rst, dvi_rst, ready, relock_cnt} !== {2'd0, 1'b1, 1'b1, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL loss_detect: got st=%0d pr=%b dr=%b rdy=%b relock=%0d expected st=0 pr=1 dr=1 rdy=0 relock=1",
                     state, pll_rst, dvi_rst, ready, relock_cnt);
        end
    endtask

    task automatic test_stable_drop();
        int budget;
        budget = 0;
        while (state !== 2'd2 && budget < 20) begin
            tick();
            budget++;
        end
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL stable_reach: got st=%0d expected 2 within 20 cycles", state);
        end
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL stable_hold: got st=%0d expected 2", state);
        end
        tick();
        n_checks++;
        if (state !== 2'd0 || relock_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL stable_drop: got st=%0d relock=%0d expected st=0 relock=1", state, relock_cnt);
        end
        for (int i = 1; i <= 13; i++) begin
            logic [1:0] exp;
            tick();
            if (i <= 3) exp = 2'd0;
            else if (i == 4) exp = 2'd1;
            else if (i <= 12) exp = 2'd2;
            else exp = 2'd3;
            n_checks++;
            if (state !== exp) begin
                n_fail++;
                $display("FAIL stable_restart: edge %0d got st=%0d expected %0d", i, state, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        int budget;
        pll_locked = 1'b0;
        budget = 0;
        while (state !== 2'd0 && budget < 10) begin
            tick();
            budget++;
        end
        n_checks++;
        if (state !== 2'd0 || relock_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL sim_second_loss: got st=%0d relock=%0d expected st=0 relock=2", state, relock_cnt);
        end
        repeat (4) tick();
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL sim_wait_enter: got st=%0d expected 1", state);
        end
        repeat (17) tick();
        pll_locked = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL sim_wait_hold: got st=%0d expected 1", state);
        end
        tick();
        n_checks++;
        if (state !== 2'd2 || timeout_cnt !== 8'd0 || pll_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_lock_wins: got st=%0d timeout=%0d pr=%b expected st=2 timeout=0 pr=0",
                     state, timeout_cnt, pll_rst);
        end
        repeat (7) tick();
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL sim_stable_len: got st=%0d expected 2", state);
        end
        tick();
        n_checks++;
        if (state !== 2'd3 || relock_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL sim_run: got st=%0d relock=%0d expected st=3 relock=2", state, relock_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        n_checks++;
        if ({state, pll_rst, dvi_rst, ready, relock_cnt, timeout_cnt} !==
            {2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL midrun_reset: got st=%0d pr=%b dr=%b rdy=%b relock=%0d timeout=%0d expected 0 1 1 0 0 0",
                     state, pll_rst, dvi_rst, ready, relock_cnt, timeout_cnt);
        end
        rst = 1'b0;
        do_bringup("rerun");
    endtask

    task automatic test_timeout();
        int exp_cnt;
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (pll_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL to_first_fall: got pr=%b expected 0", pll_rst);
        end
        for (int k = 1; k <= 300; k++) begin
            for (int i = 1; i <= 19; i++) begin
                tick();
                if (k <= 3) begin
                    n_checks++;
                    if (pll_rst !== 1'b0) begin
                        n_fail++;
                        $display("FAIL to_low_window: retry %0d cycle %0d got pr=%b expected 0", k, i, pll_rst);
                    end
                end
            end
            tick();
            exp_cnt = (k > 255) ? 255 : k;
            n_checks++;
            if (pll_rst !== 1'b1 || timeout_cnt !== exp_cnt[7:0]) begin
                n_fail++;
                $display("FAIL to_count: retry %0d got pr=%b timeout=%0d expected pr=1 timeout=%0d",
                         k, pll_rst, timeout_cnt, exp_cnt);
            end
            for (int i = 1; i <= 3; i++) begin
                tick();
                if (k <= 3) begin
                    n_checks++;
                    if (pll_rst !== 1'b1) begin
                        n_fail++;
                        $display("FAIL to_high_window: retry %0d cycle %0d got pr=%b expected 1", k, i, pll_rst);
                    end
                end
            end
            tick();
            n_checks++;
            if (pll_rst !== 1'b0 || state !== 2'd1) begin
                n_fail++;
                $display("FAIL to_refall: retry %0d got pr=%b st=%0d expected pr=0 st=1", k, pll_rst, state);
            end
        end
        n_checks++;
        if (timeout_cnt !== 8'd255 || relock_cnt !== 8'd0 || dvi_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL to_saturate: got timeout=%0d relock=%0d dr=%b expected 255 0 1",
                     timeout_cnt, relock_cnt, dvi_rst);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_bringup();
        test_run_glitch();
        test_stable_drop();
        test_simultaneous();
        test_reset_mid_run();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
